countdown_timer_bank: RTL and testbench

Bank of CHANNELS independent countdown timers sharing one internal tick prescaler. Each channel loads a WIDTH-bit seconds value and counts down once per tick. It supports one-shot or periodic (auto-reload) mode, pause/resume and abort. Each channel reports a one-cycle done pulse and a sticky expired level. It feeds the lab-control FSMs that today each instantiate their own single-channel timer.

---
 rtl/timer_pkg.sv | 18 +
 rtl/tick_gen.sv | 33 +++
 rtl/countdown_timer_bank.sv | 113 +++++++++++
 tb/tb_countdown_timer_bank.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer bank.
package timer_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    RUN,
    HOLD,
    EXPIRED
  } timer_state_t;

  // LSB of channel ch inside a flattened CHANNELS*width bus.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clock cycles.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // tick is registered so it is low during reset even when TICK_DIV is 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of independent countdown timers driven by one shared tick prescaler.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH    = 10,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       stop,
  input  logic [CHANNELS-1:0]       pause,
  input  logic [CHANNELS-1:0]       periodic,
  input  logic [CHANNELS*WIDTH-1:0] load_value,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       expired,
  output logic [CHANNELS-1:0]       done_pulse,
  output logic                      tick
);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int unsigned LSB = chan_lsb(i, WIDTH);

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] load;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    assign load = load_value[LSB +: WIDTH];

    always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      if (stop[i]) begin
        state_d = IDLE;
        count_d = '0;
      end else if (start[i]) begin
        reload_d = load;
        mode_d   = periodic[i];
        if (load != '0) begin
          state_d = RUN;
          count_d = load;
        end else begin
          // Zero-period periodic parks in IDLE rather than free-running.
          done_d  = 1'b1;
          count_d = '0;
          state_d = periodic[i] ? IDLE : EXPIRED;
        end
      end else begin
        unique case (state_q)
          RUN, HOLD: begin
            if (pause[i]) begin
              state_d = HOLD;
            end else begin
              state_d = RUN;
              if (tick) begin
                if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
                end else begin
                  done_d = 1'b1;
                  if (mode_q) begin
                    count_d = reload_q;
                  end else begin
                    count_d = '0;
                    state_d = EXPIRED;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        count_q  <= '0;
        reload_q <= '0;
        mode_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        count_q  <= count_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        done_q   <= done_d;
      end
    end

    assign count[LSB +: WIDTH] = count_q;
    assign busy[i]             = (state_q == RUN) || (state_q == HOLD);
    assign expired[i]          = (state_q == EXPIRED);
    assign done_pulse[i]       = done_q;
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed self-checking bench: TICK_DIV=4 instance plus a TICK_DIV=1 instance.
module tb_countdown_timer_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  start, stop, pause, periodic;
  logic [39:0] load_value;
  logic [39:0] count;
  logic [3:0]  busy, expired, done_pulse;
  logic        tick;

  logic [3:0]  b_start, b_stop, b_pause, b_periodic;
  logic [39:0] b_load_value;
  logic [39:0] b_count;
  logic [3:0]  b_busy, b_expired, b_done;
  logic        b_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  countdown_timer_bank #(.WIDTH(10), .CHANNELS(4), .TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .periodic(periodic), .load_value(load_value), .count(count), .busy(busy),
    .expired(expired), .done_pulse(done_pulse), .tick(tick)
  );

  countdown_timer_bank #(.WIDTH(10), .CHANNELS(4), .TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .pause(b_pause),
    .periodic(b_periodic), .load_value(b_load_value), .count(b_count), .busy(b_busy),
    .expired(b_expired), .done_pulse(b_done), .tick(b_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] cnt(input int ch);
    return count[ch*10 +: 10];
  endfunction

  function automatic logic [9:0] b_cnt(input int ch);
    return b_count[ch*10 +: 10];
  endfunction

  task automatic set_load(input int ch, input logic [9:0] v);
    load_value[ch*10 +: 10] = v;
  endtask

  // Advance until tick is high in the current cycle; the next edge consumes it.
  task automatic wait_tick(input string name);
    for (int k = 0; k < 10 && tick !== 1'b1; k++) step();
    total++;
    if (tick !== 1'b1) begin bad++; $display("FAIL %s_tick_timeout: tick=%b want 1", name, tick); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = '0; stop = '0; pause = '0; periodic = '0; load_value = '0;
    b_start = '0; b_stop = '0; b_pause = '0; b_periodic = '0; b_load_value = '0;
    step(); step();
    total++;
    if (count !== '0 || busy !== '0 || expired !== '0 || done_pulse !== '0 || tick !== 1'b0) begin
      bad++; $display("FAIL reset_state: count=%h busy=%b exp=%b done=%b tick=%b want all 0",
                      count, busy, expired, done_pulse, tick);
    end
    total++;
    if (b_count !== '0 || b_busy !== '0 || b_tick !== 1'b0) begin
      bad++; $display("FAIL reset_state_div1: count=%h busy=%b tick=%b want 0", b_count, b_busy, b_tick);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_oneshot();
    set_load(0, 10'd3); start[0] = 1'b1;
    step(); start[0] = 1'b0;
    total++;
    if (cnt(0) !== 10'd3 || busy[0] !== 1'b1) begin
      bad++; $display("FAIL oneshot_load: count=%0d busy=%b want 3 1", cnt(0), busy[0]);
    end
    for (int e = 2; e >= 1; e--) begin
      wait_tick("oneshot"); step();
      total++;
      if (cnt(0) !== 10'(e) || done_pulse[0] !== 1'b0) begin
        bad++; $display("FAIL oneshot_dec: count=%0d done=%b want %0d 0", cnt(0), done_pulse[0], e);
      end
    end
    wait_tick("oneshot"); step();
    total++;
    if (cnt(0) !== 10'd0 || done_pulse[0] !== 1'b1 || expired[0] !== 1'b1 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL oneshot_zero: count=%0d done=%b exp=%b busy=%b want 0 1 1 0",
                      cnt(0), done_pulse[0], expired[0], busy[0]);
    end
    step();
    total++;
    if (done_pulse[0] !== 1'b0 || expired[0] !== 1'b1) begin
      bad++; $display("FAIL oneshot_pulse_width: done=%b exp=%b want 0 1", done_pulse[0], expired[0]);
    end
    wait_tick("oneshot"); step();
    total++;
    if (cnt(0) !== 10'd0 || done_pulse[0] !== 1'b0 || expired[0] !== 1'b1) begin
      bad++; $display("FAIL oneshot_after: count=%0d done=%b exp=%b want 0 0 1",
                      cnt(0), done_pulse[0], expired[0]);
    end
  endtask

  task automatic test_periodic();
    int n;
    set_load(1, 10'd2); periodic[1] = 1'b1; start[1] = 1'b1;
    step(); start[1] = 1'b0; periodic[1] = 1'b0;
    wait_tick("periodic"); step();
    total++;
    if (cnt(1) !== 10'd1 || done_pulse[1] !== 1'b0) begin
      bad++; $display("FAIL periodic_dec: count=%0d done=%b want 1 0", cnt(1), done_pulse[1]);
    end
    wait_tick("periodic"); step();
    total++;
    if (cnt(1) !== 10'd2 || done_pulse[1] !== 1'b1 || expired[1] !== 1'b0 || busy[1] !== 1'b1) begin
      bad++; $display("FAIL periodic_reload: count=%0d done=%b exp=%b busy=%b want 2 1 0 1",
                      cnt(1), done_pulse[1], expired[1], busy[1]);
    end
    n = 0;
    do begin step(); n++; end while (done_pulse[1] !== 1'b1 && n < 20);
    total++;
    if (n !== 8) begin bad++; $display("FAIL periodic_period: cycles=%0d want 8", n); end
    stop[1] = 1'b1; step(); stop[1] = 1'b0;
    total++;
    if (cnt(1) !== 10'd0 || busy[1] !== 1'b0 || expired[1] !== 1'b0) begin
      bad++; $display("FAIL periodic_stop: count=%0d busy=%b exp=%b want 0 0 0",
                      cnt(1), busy[1], expired[1]);
    end
  endtask

  task automatic test_pause();
    set_load(2, 10'd5); start[2] = 1'b1;
    step(); start[2] = 1'b0;
    wait_tick("pause"); step();
    wait_tick("pause"); step();
    total++;
    if (cnt(2) !== 10'd3) begin bad++; $display("FAIL pause_pre: count=%0d want 3", cnt(2)); end
    pause[2] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_tick("pause"); step();
      total++;
      if (cnt(2) !== 10'd3 || busy[2] !== 1'b1) begin
        bad++; $display("FAIL pause_hold: count=%0d busy=%b want 3 1", cnt(2), busy[2]);
      end
    end
    pause[2] = 1'b0;
    for (int e = 2; e >= 1; e--) begin
      wait_tick("pause"); step();
      total++;
      if (cnt(2) !== 10'(e) || busy[2] !== 1'b1 || done_pulse[2] !== 1'b0) begin
        bad++; $display("FAIL pause_resume: count=%0d busy=%b done=%b want %0d 1 0",
                        cnt(2), busy[2], done_pulse[2], e);
      end
    end
    wait_tick("pause"); step();
    total++;
    if (cnt(2) !== 10'd0 || done_pulse[2] !== 1'b1) begin
      bad++; $display("FAIL pause_done: count=%0d done=%b want 0 1", cnt(2), done_pulse[2]);
    end
  endtask

  task automatic test_priority();
    stop[0] = 1'b1; step(); stop[0] = 1'b0;
    set_load(0, 10'd0); periodic[0] = 1'b0; start[0] = 1'b1;
    step(); start[0] = 1'b0;
    total++;
    if (done_pulse[0] !== 1'b1 || expired[0] !== 1'b1 || cnt(0) !== 10'd0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL zero_load: done=%b exp=%b count=%0d busy=%b want 1 1 0 0",
                      done_pulse[0], expired[0], cnt(0), busy[0]);
    end
    step();
    total++;
    if (done_pulse[0] !== 1'b0 || expired[0] !== 1'b1) begin
      bad++; $display("FAIL zero_load_after: done=%b exp=%b want 0 1", done_pulse[0], expired[0]);
    end
    set_load(1, 10'd5); start[1] = 1'b1; stop[1] = 1'b1;
    step(); start[1] = 1'b0; stop[1] = 1'b0;
    total++;
    if (busy[1] !== 1'b0 || cnt(1) !== 10'd0) begin
      bad++; $display("FAIL start_stop: busy=%b count=%0d want 0 0", busy[1], cnt(1));
    end
    set_load(2, 10'd4); start[2] = 1'b1;
    step();
    set_load(2, 10'd7);
    step(); start[2] = 1'b0;
    total++;
    if (cnt(2) !== 10'd7 || busy[2] !== 1'b1) begin
      bad++; $display("FAIL restart: count=%0d busy=%b want 7 1", cnt(2), busy[2]);
    end
    wait_tick("coincident");
    set_load(3, 10'd6); start[3] = 1'b1;
    step(); start[3] = 1'b0;
    total++;
    if (cnt(3) !== 10'd6) begin bad++; $display("FAIL tick_with_start: count=%0d want 6", cnt(3)); end
    wait_tick("coincident"); step();
    total++;
    if (cnt(3) !== 10'd5) begin bad++; $display("FAIL tick_after_start: count=%0d want 5", cnt(3)); end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 4; c++) set_load(c, 10'd100);
    start = 4'hf; step(); start = '0;
    step(); step();
    reset = 1'b1;
    #2;
    total++;
    if (count !== '0 || busy !== '0 || expired !== '0 || done_pulse !== '0 || tick !== 1'b0) begin
      bad++; $display("FAIL async_reset: count=%h busy=%b exp=%b done=%b tick=%b want all 0",
                      count, busy, expired, done_pulse, tick);
    end
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (tick !== (k == 3) || busy !== '0) begin
        bad++; $display("FAIL prescaler_restart: edge=%0d tick=%b busy=%b want %b 0",
                        k, tick, busy, (k == 3));
      end
    end
  endtask

  task automatic test_max_independence();
    int n, miss;
    b_load_value[30 +: 10] = 10'd1023;
    b_load_value[0 +: 10]  = 10'd1;
    b_periodic = 4'b0001; b_start = 4'b1001;
    step(); b_start = '0; b_periodic = '0;
    total++;
    if (b_cnt(3) !== 10'd1023 || b_cnt(0) !== 10'd1) begin
      bad++; $display("FAIL max_load: ch3=%0d ch0=%0d want 1023 1", b_cnt(3), b_cnt(0));
    end
    n = 0; miss = 0;
    do begin
      step(); n++;
      if (b_done[0] !== 1'b1 || b_cnt(0) !== 10'd1) miss++;
    end while (b_done[3] !== 1'b1 && n < 1100);
    total++;
    if (n !== 1023) begin bad++; $display("FAIL max_latency: cycles=%0d want 1023", n); end
    total++;
    if (miss !== 0) begin bad++; $display("FAIL periodic_every_cycle: misses=%0d want 0", miss); end
    total++;
    if (b_expired !== 4'b1000 || b_cnt(3) !== 10'd0) begin
      bad++; $display("FAIL max_expired: exp=%b ch3=%0d want 1000 0", b_expired, b_cnt(3));
    end
    step();
    total++;
    if (b_done !== 4'b0001) begin bad++; $display("FAIL independence: done=%b want 0001", b_done); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_priority();
    test_async_reset();
    test_max_independence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
